uart_link_responder: RTL and testbench

- Far end of the UART ack/retry link on the remote board.
- Accepts data bytes from the UART receiver and returns ACK byte 204 for every byte it accepts.
- Buffers accepted bytes in a small FIFO and replays them onto the system bus as single writes at auto-incrementing addresses.
- Withholding the ACK when the FIFO is full is the backpressure: the sender times out and retransmits.

---
 rtl/bus_link_pkg.sv | 19 +
 rtl/link_fifo.sv | 52 +++++
 rtl/uart_link_responder.sv | 219 +++++++++++++++++++++
 tb/tb_uart_link_responder.sv | 378 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_link_pkg.sv
// Shared constants and FSM encodings for the UART ack/retry link responder.
package bus_link_pkg;

  localparam int ACK_BYTE_DEFAULT = 204;

  localparam logic [1:0] INSTR_IDLE  = 2'b00;
  localparam logic [1:0] INSTR_WRITE = 2'b10;

  typedef enum logic [1:0] {
    A_IDLE      = 2'b00,
    A_WAIT_DONE = 2'b01
  } ack_state_t;

  typedef enum logic [1:0] {
    M_IDLE = 2'b00,
    M_OUT  = 2'b01
  } mst_state_t;

endpackage

// File: rtl/link_fifo.sv
// Small synchronous FIFO buffering accepted link bytes; output is first-word fall-through.
module link_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_link_responder.sv
// Remote end of the UART ack/retry link: ACKs accepted bytes and replays them as bus writes.
// Optional duplicate filter for lost-ACK retransmissions is enabled with LINK_DUP_FILTER_EN.
module uart_link_responder
  import bus_link_pkg::*;
#(
  parameter int SLAVE_LEN    = 2,
  parameter int ADDR_LEN     = 12,
  parameter int DATA_LEN     = 8,
  parameter int BURST_LEN    = 12,
  parameter int ACK_BYTE     = ACK_BYTE_DEFAULT,
  parameter int FIFO_DEPTH   = 4,
  parameter int TARGET_SLAVE = 1,
  parameter int BASE_ADDR    = 0,
  parameter int DUP_WINDOW   = 60000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 u_receive_sig,
  input  logic [DATA_LEN-1:0]  u_data_in,
  input  logic                 u_tx_busy,
  input  logic                 u_tx_done,
  output logic                 u_send_sig,
  output logic [DATA_LEN-1:0]  u_data_out,
  input  logic                 m_tx_done,
  output logic [1:0]           m_instruction,
  output logic [SLAVE_LEN-1:0] m_slave_select,
  output logic [ADDR_LEN-1:0]  m_address,
  output logic [DATA_LEN-1:0]  m_data_out,
  output logic [BURST_LEN-1:0] m_burst_num,
  output logic                 rx_drop
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  ack_state_t a_state, a_next;
  mst_state_t m_state, m_next;

  logic                pend_valid, pend_valid_next;
  logic [DATA_LEN-1:0] pend_data, pend_data_next;
  logic                arr_valid;
  logic [DATA_LEN-1:0] arr_data;
  logic                is_dup;
  logic                ack_now, push, drop_now;

  logic                fifo_full, fifo_empty, pop;
  logic [DATA_LEN-1:0] fifo_dout;
  logic [CNT_W-1:0]    unused_fifo_count;

  logic [ADDR_LEN-1:0] addr_ptr, ptr_next, addr_next;
  logic [1:0]          instr_next;
  logic [DATA_LEN-1:0] mdata_next;

  link_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(DATA_LEN)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (arr_data),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (unused_fifo_count)
  );

  // A parked byte takes priority over the input port so arrival order is preserved.
  assign arr_valid = pend_valid || u_receive_sig;
  assign arr_data  = pend_valid ? pend_data : u_data_in;

`ifdef LINK_DUP_FILTER_EN
  localparam int WIN_W = $clog2(DUP_WINDOW + 1);

  logic [WIN_W-1:0]    win_cnt;
  logic [DATA_LEN-1:0] last_byte;

  assign is_dup = (arr_data == last_byte) && (win_cnt < WIN_W'(DUP_WINDOW));

  always_ff @(posedge clk) begin
    if (!reset) begin
      win_cnt   <= WIN_W'(DUP_WINDOW);
      last_byte <= '0;
    end else begin
      if (ack_now) last_byte <= arr_data;
      if (a_state == A_WAIT_DONE && u_tx_done) win_cnt <= '0;
      else if (win_cnt < WIN_W'(DUP_WINDOW)) win_cnt <= win_cnt + 1'b1;
    end
  end
`else
  localparam int unused_dup_window = DUP_WINDOW;
  assign is_dup = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) a_state <= A_IDLE;
    else        a_state <= a_next;
  end

  always_comb begin
    a_next = A_IDLE;
    case (a_state)
      A_IDLE:      a_next = ack_now ? A_WAIT_DONE : A_IDLE;
      A_WAIT_DONE: a_next = u_tx_done ? A_IDLE : A_WAIT_DONE;
      default:     a_next = A_IDLE;
    endcase
  end

  always_comb begin
    ack_now         = 1'b0;
    push            = 1'b0;
    drop_now        = 1'b0;
    pend_valid_next = pend_valid;
    pend_data_next  = pend_data;
    case (a_state)
      A_IDLE: begin
        if (arr_valid && u_tx_busy) begin
          if (u_receive_sig && !pend_valid) begin
            pend_valid_next = 1'b1;
            pend_data_next  = u_data_in;
          end else if (u_receive_sig) begin
            drop_now = 1'b1;
          end
        end else if (arr_valid) begin
          pend_valid_next = pend_valid && u_receive_sig;
          if (pend_valid && u_receive_sig) pend_data_next = u_data_in;
          if (is_dup) begin
            ack_now = 1'b1;
          end else if (!fifo_full) begin
            ack_now = 1'b1;
            push    = 1'b1;
          end else begin
            drop_now = 1'b1;
          end
        end
      end
      A_WAIT_DONE: begin
        if (u_receive_sig && !pend_valid) begin
          pend_valid_next = 1'b1;
          pend_data_next  = u_data_in;
        end else if (u_receive_sig) begin
          drop_now = 1'b1;
        end
      end
      default: pend_valid_next = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pend_valid <= 1'b0;
      pend_data  <= '0;
      u_send_sig <= 1'b0;
      u_data_out <= '0;
      rx_drop    <= 1'b0;
    end else begin
      pend_valid <= pend_valid_next;
      pend_data  <= pend_data_next;
      u_send_sig <= ack_now;
      rx_drop    <= drop_now;
      if (ack_now) u_data_out <= DATA_LEN'(ACK_BYTE);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) m_state <= M_IDLE;
    else        m_state <= m_next;
  end

  always_comb begin
    m_next = M_IDLE;
    case (m_state)
      M_IDLE:  m_next = fifo_empty ? M_IDLE : M_OUT;
      M_OUT:   m_next = m_tx_done ? M_IDLE : M_OUT;
      default: m_next = M_IDLE;
    endcase
  end

  always_comb begin
    pop        = 1'b0;
    instr_next = m_instruction;
    addr_next  = m_address;
    mdata_next = m_data_out;
    ptr_next   = addr_ptr;
    case (m_state)
      M_IDLE: begin
        instr_next = INSTR_IDLE;
        if (!fifo_empty) begin
          pop        = 1'b1;
          instr_next = INSTR_WRITE;
          addr_next  = addr_ptr;
          mdata_next = fifo_dout;
        end
      end
      M_OUT: begin
        if (m_tx_done) begin
          instr_next = INSTR_IDLE;
          ptr_next   = addr_ptr + 1'b1;
        end
      end
      default: instr_next = INSTR_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      m_instruction <= INSTR_IDLE;
      m_address     <= ADDR_LEN'(BASE_ADDR);
      m_data_out    <= '0;
      addr_ptr      <= ADDR_LEN'(BASE_ADDR);
    end else begin
      m_instruction <= instr_next;
      m_address     <= addr_next;
      m_data_out    <= mdata_next;
      addr_ptr      <= ptr_next;
    end
  end

  assign m_slave_select = SLAVE_LEN'(TARGET_SLAVE);
  assign m_burst_num    = '0;

endmodule

// File: tb/tb_uart_link_responder.sv
// Scoreboard bench for uart_link_responder; expected bus writes are queued as bytes are sent.
// Define LINK_DUP_FILTER_EN for both bench and RTL to exercise the duplicate filter.
module tb_uart_link_responder;

  localparam int DUP_WIN = 300;

  logic        clk;
  logic        reset;
  logic        u_receive_sig;
  logic [7:0]  u_data_in;
  logic        u_tx_busy;
  logic        u_tx_done;
  logic        u_send_sig;
  logic [7:0]  u_data_out;
  logic        m_tx_done;
  logic [1:0]  m_instruction;
  logic [1:0]  m_slave_select;
  logic [11:0] m_address;
  logic [7:0]  m_data_out;
  logic [11:0] m_burst_num;
  logic        rx_drop;

  int checks = 0;
  int failures = 0;
  int ack_count = 0;
  int drop_count = 0;
  int write_count = 0;
  int ack_delay = 1;
  int tx_cnt = 0;
  bit bus_auto = 1'b1;
  bit prev_write = 1'b0;
  logic [19:0] exp_q[$];
  logic [11:0] exp_addr = 12'h000;
  logic [11:0] last_addr = 12'h000;

  uart_link_responder #(.DUP_WINDOW(DUP_WIN)) dut (
    .clk            (clk),
    .reset          (reset),
    .u_receive_sig  (u_receive_sig),
    .u_data_in      (u_data_in),
    .u_tx_busy      (u_tx_busy),
    .u_tx_done      (u_tx_done),
    .u_send_sig     (u_send_sig),
    .u_data_out     (u_data_out),
    .m_tx_done      (m_tx_done),
    .m_instruction  (m_instruction),
    .m_slave_select (m_slave_select),
    .m_address      (m_address),
    .m_data_out     (m_data_out),
    .m_burst_num    (m_burst_num),
    .rx_drop        (rx_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // UART and bus responders plus the write scoreboard, sampled 2 time units after each edge.
  initial begin
    logic [19:0] exp;
    m_tx_done = 1'b0;
    u_tx_done = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      m_tx_done = bus_auto && (m_instruction == 2'b10) && !m_tx_done;
      if (u_send_sig) begin
        tx_cnt = ack_delay;
        u_tx_done = 1'b0;
      end else if (tx_cnt > 0) begin
        tx_cnt--;
        u_tx_done = (tx_cnt == 0);
      end else begin
        u_tx_done = 1'b0;
      end
      if (u_send_sig) begin
        ack_count++;
        checks++;
        if (u_data_out !== 8'd204) begin
          failures++;
          $display("[TB] FAIL ack_byte: got %0d expected 204", u_data_out);
        end
      end
      if (rx_drop) drop_count++;
      if (m_instruction == 2'b10 && !prev_write) begin
        write_count++;
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("[TB] FAIL unexpected_write: got addr %0h data %0h expected none", m_address, m_data_out);
        end else begin
          exp = exp_q.pop_front();
          if ({m_address, m_data_out} !== exp || m_slave_select !== 2'd1 || m_burst_num !== 12'd0) begin
            failures++;
            $display("[TB] FAIL bus_write: got addr %0h data %0h slave %0d burst %0d expected addr %0h data %0h slave 1 burst 0",
                     m_address, m_data_out, m_slave_select, m_burst_num, exp[19:8], exp[7:0]);
          end
          last_addr = m_address;
        end
      end
      prev_write = (m_instruction == 2'b10);
    end
  end

  initial begin
    #5000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic pulse_byte(input logic [7:0] b);
    @(negedge clk);
    u_receive_sig = 1'b1;
    u_data_in = b;
    @(negedge clk);
    u_receive_sig = 1'b0;
  endtask

  task automatic expect_write(input logic [7:0] b);
    exp_q.push_back({exp_addr, b});
    exp_addr = exp_addr + 12'd1;
  endtask

  task automatic wait_ack_done();
    int n = 0;
    while (u_tx_done !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (u_tx_done !== 1'b1) begin
      failures++;
      $display("[TB] FAIL ack_done_timeout: got no u_tx_done expected one within 100 cycles");
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    u_receive_sig = 1'b0;
    u_data_in = 8'h00;
    u_tx_busy = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (u_send_sig !== 1'b0)       begin failures++; $display("[TB] FAIL rst_send: got %0b expected 0", u_send_sig); end
    checks++; if (u_data_out !== 8'h00)      begin failures++; $display("[TB] FAIL rst_udata: got %0h expected 0", u_data_out); end
    checks++; if (rx_drop !== 1'b0)          begin failures++; $display("[TB] FAIL rst_drop: got %0b expected 0", rx_drop); end
    checks++; if (m_instruction !== 2'b00)   begin failures++; $display("[TB] FAIL rst_instr: got %0b expected 00", m_instruction); end
    checks++; if (m_slave_select !== 2'd1)   begin failures++; $display("[TB] FAIL rst_slave: got %0d expected 1", m_slave_select); end
    checks++; if (m_address !== 12'h000)     begin failures++; $display("[TB] FAIL rst_addr: got %0h expected 0", m_address); end
    checks++; if (m_data_out !== 8'h00)      begin failures++; $display("[TB] FAIL rst_mdata: got %0h expected 0", m_data_out); end
    checks++; if (m_burst_num !== 12'd0)     begin failures++; $display("[TB] FAIL rst_burst: got %0d expected 0", m_burst_num); end
    reset = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (m_instruction !== 2'b00 || write_count != 0) begin
      failures++;
      $display("[TB] FAIL rst_idle: got instr %0b writes %0d expected 00 and 0", m_instruction, write_count);
    end
  endtask

  task automatic test_basic();
    int acks0 = ack_count;
    bus_auto = 1'b0;
    expect_write(8'h5A);
    pulse_byte(8'h5A);
    checks++;
    if (u_send_sig !== 1'b1 || u_data_out !== 8'd204) begin
      failures++;
      $display("[TB] FAIL basic_ack_latency: got send %0b data %0d expected 1 and 204", u_send_sig, u_data_out);
    end
    @(negedge clk);
    checks++;
    if (m_instruction !== 2'b10 || m_address !== 12'h000 || m_data_out !== 8'h5A || m_slave_select !== 2'd1) begin
      failures++;
      $display("[TB] FAIL basic_write_latency: got instr %0b addr %0h data %0h slave %0d expected 10 0 5a 1",
               m_instruction, m_address, m_data_out, m_slave_select);
    end
    repeat (6) @(negedge clk);
    checks++;
    if (m_instruction !== 2'b10 || m_address !== 12'h000 || m_data_out !== 8'h5A) begin
      failures++;
      $display("[TB] FAIL basic_hold: got instr %0b addr %0h data %0h expected 10 0 5a", m_instruction, m_address, m_data_out);
    end
    bus_auto = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (m_instruction !== 2'b00) begin
      failures++;
      $display("[TB] FAIL basic_release: got %0b expected 00", m_instruction);
    end
    expect_write(8'hC3);
    pulse_byte(8'hC3);
    wait_ack_done();
    repeat (5) @(negedge clk);
    checks++;
    if (exp_q.size() != 0 || last_addr !== 12'h001 || ack_count - acks0 != 2) begin
      failures++;
      $display("[TB] FAIL basic_second: got pending %0d last_addr %0h acks %0d expected 0 1 2",
               exp_q.size(), last_addr, ack_count - acks0);
    end
  endtask

  task automatic test_backpressure();
    int acks0 = ack_count;
    int drops0 = drop_count;
    bus_auto = 1'b0;
    // The first byte leaves the FIFO for the stalled bus write, so four more fill it.
    for (int i = 0; i < 5; i++) begin
      expect_write(8'h10 + 8'(i));
      pulse_byte(8'h10 + 8'(i));
      wait_ack_done();
    end
    pulse_byte(8'hEE);
    checks++;
    if (rx_drop !== 1'b1 || u_send_sig !== 1'b0) begin
      failures++;
      $display("[TB] FAIL full_drop: got drop %0b send %0b expected 1 0", rx_drop, u_send_sig);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (ack_count - acks0 != 5 || drop_count - drops0 != 1) begin
      failures++;
      $display("[TB] FAIL full_counts: got acks %0d drops %0d expected 5 1", ack_count - acks0, drop_count - drops0);
    end
    bus_auto = 1'b1;
    repeat (30) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL full_drain: got %0d writes outstanding expected 0", exp_q.size());
    end
  endtask

  task automatic test_pending();
    int acks0 = ack_count;
    int drops0 = drop_count;
    bus_auto = 1'b1;
    ack_delay = 8;
    expect_write(8'hA1);
    pulse_byte(8'hA1);
    expect_write(8'hA2);
    pulse_byte(8'hA2);
    pulse_byte(8'hA3);
    checks++;
    if (rx_drop !== 1'b1) begin
      failures++;
      $display("[TB] FAIL pend_drop: got %0b expected 1", rx_drop);
    end
    wait_ack_done();
    @(negedge clk);
    checks++;
    if (u_send_sig !== 1'b1) begin
      failures++;
      $display("[TB] FAIL pend_ack: got %0b expected 1", u_send_sig);
    end
    wait_ack_done();
    ack_delay = 1;
    repeat (10) @(negedge clk);
    checks++;
    if (ack_count - acks0 != 2 || drop_count - drops0 != 1 || exp_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL pend_counts: got acks %0d drops %0d pending %0d expected 2 1 0",
               ack_count - acks0, drop_count - drops0, exp_q.size());
    end
  endtask

  task automatic test_wrap();
    int n = 4096 - int'(exp_addr) + 2;
    bus_auto = 1'b1;
    for (int i = 0; i < n; i++) begin
      expect_write(8'(i));
      pulse_byte(8'(i));
      wait_ack_done();
    end
    repeat (10) @(negedge clk);
    checks++;
    if (exp_q.size() != 0 || last_addr !== 12'h001) begin
      failures++;
      $display("[TB] FAIL wrap: got pending %0d last_addr %0h expected 0 001", exp_q.size(), last_addr);
    end
  endtask

  task automatic test_reset_mid();
    int writes0;
    bus_auto = 1'b0;
    expect_write(8'h11);
    pulse_byte(8'h11);
    wait_ack_done();
    pulse_byte(8'h22);
    wait_ack_done();
    checks++;
    if (m_instruction !== 2'b10) begin
      failures++;
      $display("[TB] FAIL mid_busy: got %0b expected 10", m_instruction);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (m_instruction !== 2'b00 || m_address !== 12'h000 || m_data_out !== 8'h00 ||
        u_send_sig !== 1'b0 || u_data_out !== 8'h00 || rx_drop !== 1'b0 || m_slave_select !== 2'd1) begin
      failures++;
      $display("[TB] FAIL mid_reset: got instr %0b addr %0h mdata %0h send %0b udata %0h drop %0b slave %0d expected reset values",
               m_instruction, m_address, m_data_out, u_send_sig, u_data_out, rx_drop, m_slave_select);
    end
    reset = 1'b1;
    exp_addr = 12'h000;
    bus_auto = 1'b1;
    writes0 = write_count;
    repeat (6) @(negedge clk);
    checks++;
    if (write_count != writes0 || m_instruction !== 2'b00) begin
      failures++;
      $display("[TB] FAIL mid_fifo_empty: got writes %0d instr %0b expected %0d 00", write_count, m_instruction, writes0);
    end
    expect_write(8'h77);
    pulse_byte(8'h77);
    wait_ack_done();
    repeat (5) @(negedge clk);
    checks++;
    if (exp_q.size() != 0 || last_addr !== 12'h000) begin
      failures++;
      $display("[TB] FAIL mid_restart: got pending %0d last_addr %0h expected 0 000", exp_q.size(), last_addr);
    end
  endtask

  task automatic test_repeat_byte();
    int acks0 = ack_count;
    int writes0 = write_count;
    bus_auto = 1'b1;
    expect_write(8'h33);
    pulse_byte(8'h33);
    wait_ack_done();
    repeat (100) @(negedge clk);
`ifndef LINK_DUP_FILTER_EN
    expect_write(8'h33);
`endif
    pulse_byte(8'h33);
    wait_ack_done();
    repeat (10) @(negedge clk);
`ifdef LINK_DUP_FILTER_EN
    checks++;
    if (ack_count - acks0 != 2 || write_count - writes0 != 1) begin
      failures++;
      $display("[TB] FAIL dup_inside: got acks %0d writes %0d expected 2 1", ack_count - acks0, write_count - writes0);
    end
    repeat (DUP_WIN + 20) @(negedge clk);
    expect_write(8'h33);
    pulse_byte(8'h33);
    wait_ack_done();
    repeat (10) @(negedge clk);
    checks++;
    if (ack_count - acks0 != 3 || write_count - writes0 != 2 || exp_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL dup_outside: got acks %0d writes %0d pending %0d expected 3 2 0",
               ack_count - acks0, write_count - writes0, exp_q.size());
    end
`else
    checks++;
    if (ack_count - acks0 != 2 || write_count - writes0 != 2 || exp_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL repeat_byte: got acks %0d writes %0d pending %0d expected 2 2 0",
               ack_count - acks0, write_count - writes0, exp_q.size());
    end
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_pending();
    test_wrap();
    test_reset_mid();
    test_repeat_byte();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
